inpkt_type_demux: RTL



---
 rtl/inpkt_type_demux_pkg.sv | 20 ++
 rtl/inpkt_hdr_check.sv | 22 ++
 rtl/inpkt_type_demux.sv | 136 +++++++++++++
 3 files changed

// File: rtl/inpkt_type_demux_pkg.sv
// Shared packet-type constants, header geometry and FSM state encoding
// for the input-packet header parser.
package inpkt_type_demux_pkg;

  localparam logic [7:0] PKT_TYPE_WORD_LIST     = 8'h01;
  localparam logic [7:0] PKT_TYPE_WORD_GEN      = 8'h02;
  localparam logic [7:0] PKT_TYPE_CMP_CONFIG    = 8'h03;
  localparam logic [7:0] PKT_TYPE_TEMPLATE_LIST = 8'h04;
  localparam logic [7:0] PKT_TYPE_INIT          = 8'h05;

  localparam int PKT_HDR_LEN   = 8;
  localparam int PKT_LEN_WIDTH = 24;

  typedef enum logic [1:0] {
    ST_HDR     = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_ERR     = 2'd2
  } state_t;

endpackage

// File: rtl/inpkt_hdr_check.sv
// Combinational legality check of a packet type and its payload length.
module inpkt_hdr_check
  import inpkt_type_demux_pkg::*;
#(
  parameter int PKT_MAX_LEN = 65536
) (
  input  logic [7:0]               pkt_type,
  input  logic [PKT_LEN_WIDTH-1:0] pkt_len,
  output logic                     type_ok,
  output logic                     len_ok
);

  localparam logic [PKT_LEN_WIDTH-1:0] MAX_LEN = PKT_LEN_WIDTH'(PKT_MAX_LEN);
  localparam logic [PKT_LEN_WIDTH-1:0] ONE     = PKT_LEN_WIDTH'(1);

  assign type_ok = (pkt_type >= PKT_TYPE_WORD_LIST) && (pkt_type <= PKT_TYPE_INIT);

  // The INIT holding block downstream is exactly one byte deep.
  assign len_ok = (pkt_len != '0) && (pkt_len <= MAX_LEN) &&
                  ((pkt_type != PKT_TYPE_INIT) || (pkt_len == ONE));

endmodule

// File: rtl/inpkt_type_demux.sv
// Strips the 8-byte input-packet header and routes the payload to the
// INIT channel or the data channel; any header violation halts intake.
module inpkt_type_demux
  import inpkt_type_demux_pkg::*;
#(
  parameter logic [7:0] VERSION     = 8'd2,
  parameter int         PKT_MAX_LEN = 65536
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic [7:0]  din,
  input  logic        din_empty,
  output logic        din_rd_en,
  output logic [7:0]  init_dout,
  output logic        init_wr_en,
  input  logic        init_full,
  output logic [7:0]  data_dout,
  output logic        data_wr_en,
  input  logic        data_full,
  output logic [7:0]  data_pkt_type,
  output logic [15:0] data_pkt_id,
  output logic        data_pkt_end,
  output logic        err_pkt_version,
  output logic        err_pkt_type,
  output logic        err_pkt_len
);

  localparam logic [PKT_LEN_WIDTH-1:0] ONE = PKT_LEN_WIDTH'(1);

  state_t                   state, state_nxt;
  logic [2:0]               idx;
  logic [PKT_LEN_WIDTH-1:0] len_cnt;
  logic [7:0]               hdr_type;
  logic [PKT_LEN_WIDTH-1:0] hdr_len;
  logic [7:0]               hdr_id_lo;
  logic                     sel_init, dst_full;
  logic                     set_ver, set_type, set_len;
  logic [7:0]               chk_type;
  logic                     type_ok, len_ok;

  // Type is checked live on b1; length on b4 against the type latched earlier.
  assign chk_type = (idx == 3'd1) ? din : hdr_type;

  inpkt_hdr_check #(.PKT_MAX_LEN(PKT_MAX_LEN)) u_hdr_check (
    .pkt_type (chk_type),
    .pkt_len  ({din, hdr_len[15:0]}),
    .type_ok  (type_ok),
    .len_ok   (len_ok)
  );

  assign sel_init = (data_pkt_type == PKT_TYPE_INIT);
  assign dst_full = sel_init ? init_full : data_full;

  always_comb begin
    state_nxt  = state;
    din_rd_en  = 1'b0;
    init_wr_en = 1'b0;
    data_wr_en = 1'b0;
    set_ver    = 1'b0;
    set_type   = 1'b0;
    set_len    = 1'b0;
    // Gating by RESET_N keeps every output low while reset is held.
    if (RESET_N) begin
      case (state)
        ST_HDR: begin
          din_rd_en = ~din_empty;
          if (din_rd_en) begin
            case (idx)
              3'd0: if (din != VERSION) begin set_ver  = 1'b1; state_nxt = ST_ERR; end
              3'd1: if (!type_ok)       begin set_type = 1'b1; state_nxt = ST_ERR; end
              3'd4: if (!len_ok)        begin set_len  = 1'b1; state_nxt = ST_ERR; end
              3'd7: state_nxt = ST_PAYLOAD;
              default: ;
            endcase
          end
        end
        ST_PAYLOAD: begin
          din_rd_en  = ~din_empty & ~dst_full;
          init_wr_en = din_rd_en & sel_init;
          data_wr_en = din_rd_en & ~sel_init;
          if (din_rd_en && (len_cnt == ONE)) state_nxt = ST_HDR;
        end
        default: ;
      endcase
    end
  end

  assign init_dout    = init_wr_en ? din : 8'h00;
  assign data_dout    = data_wr_en ? din : 8'h00;
  assign data_pkt_end = data_wr_en & (len_cnt == ONE);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state           <= ST_HDR;
      idx             <= 3'd0;
      len_cnt         <= '0;
      data_pkt_type   <= 8'h00;
      data_pkt_id     <= 16'h0000;
      err_pkt_version <= 1'b0;
      err_pkt_type    <= 1'b0;
      err_pkt_len     <= 1'b0;
    end else begin
      state           <= state_nxt;
      err_pkt_version <= err_pkt_version | set_ver;
      err_pkt_type    <= err_pkt_type | set_type;
      err_pkt_len     <= err_pkt_len | set_len;
      if (din_rd_en) begin
        if (state == ST_HDR) begin
          idx <= idx + 3'd1;
          if (idx == 3'd7) begin
            len_cnt       <= hdr_len;
            data_pkt_type <= hdr_type;
            data_pkt_id   <= {din, hdr_id_lo};
          end
        end else begin
          len_cnt <= len_cnt - ONE;
        end
      end
    end
  end

  // Header scratch fields; always overwritten before use, so no reset.
  always_ff @(posedge CLK) begin
    if (din_rd_en && (state == ST_HDR)) begin
      case (idx)
        3'd1: hdr_type        <= din;
        3'd2: hdr_len[7:0]    <= din;
        3'd3: hdr_len[15:8]   <= din;
        3'd4: hdr_len[23:16]  <= din;
        3'd6: hdr_id_lo       <= din;
        default: ;
      endcase
    end
  end

endmodule
